// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage between fetch and execute, with an optional skid entry
// that decouples in_ready from out_ready.
module decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b0,
    parameter bit          SKID     = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rd_we,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FmtR    = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtNone = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [6:0]      opcode;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            illegal;
    } bundle_t;

    fmt_e        fmt;
    logic [31:0] imm32;
    logic        illegal;
    bundle_t     dec;

    always_comb begin
        fmt = FmtNone;
        case (in_inst[6:0])
            7'h33:                             fmt = FmtR;
            7'h3B:                             fmt = (XLEN == 64) ? FmtR : FmtNone;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: fmt = FmtI;
            7'h1B:                             fmt = (XLEN == 64) ? FmtI : FmtNone;
            7'h23:                             fmt = FmtS;
            7'h63:                             fmt = FmtB;
            7'h37, 7'h17:                      fmt = FmtU;
            7'h6F:                             fmt = FmtJ;
            default:                           fmt = FmtNone;
        endcase

        illegal = (fmt == FmtNone) || (in_inst[1:0] != 2'b11) ||
                  (in_inst == 32'h0000_0000) || (in_inst == 32'hFFFF_FFFF);
        if (fmt == FmtR) begin
            case (in_inst[31:25])
                7'h00:   ;
                7'h20:   if (!(in_inst[14:12] == 3'd0 || in_inst[14:12] == 3'd5)) illegal = 1'b1;
                7'h01:   if (!ENABLE_M) illegal = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
        // funct3 2 and 3 are unassigned branch encodings
        if (fmt == FmtB && in_inst[14:13] == 2'b01) illegal = 1'b1;

        case (fmt)
            FmtI:    imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FmtS:    imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FmtB:    imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                              in_inst[11:8], 1'b0};
            FmtU:    imm32 = {in_inst[31:12], 12'b0};
            FmtJ:    imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                              in_inst[30:21], 1'b0};
            default: imm32 = 32'b0;
        endcase

        dec         = '0;
        dec.pc      = in_pc;
        dec.rd      = in_inst[11:7];
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.funct3  = in_inst[14:12];
        dec.funct7  = in_inst[31:25];
        dec.opcode  = in_inst[6:0];
        dec.illegal = illegal;
        dec.fmt     = illegal ? FmtNone : fmt;
        dec.imm     = illegal ? '0 : XLEN'($signed(imm32));
        dec.rd_we   = !illegal && (fmt inside {FmtR, FmtI, FmtU, FmtJ}) &&
                      (in_inst[11:7] != 5'd0) && (in_inst[6:0] != 7'h0F);
    end

    state_e  state_q;
    bundle_t out_q;
    bundle_t skid_q;
    logic    accept;

    assign out_valid = (state_q != StEmpty);
    // Without a skid entry the stage can only refill when the held bundle is leaving.
    assign in_ready  = SKID ? (state_q != StFull) : (state_q == StEmpty || out_ready);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        out_q   <= dec;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (out_ready) begin
                        if (accept) out_q <= dec;
                        else        state_q <= StEmpty;
                    end else if (accept) begin
                        skid_q  <= dec;
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        out_q   <= skid_q;
                        state_q <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign out_pc      = out_q.pc;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_opcode  = out_q.opcode;
    assign out_fmt     = out_q.fmt;
    assign out_imm     = out_q.imm;
    assign out_rd_we   = out_q.rd_we;
    assign out_illegal = out_q.illegal;

endmodule
